// File: rtl/vc_fifo.sv
// vc_fifo: NUM_VC independent circular FIFOs sharing one write port and one
// read port, each steered by a VC index. Occupancy and flags are decoded from
// the registered pointers; data_o and error_o are combinational.
module vc_fifo #(
  parameter int NUM_VC    = 3,
  parameter int SLOTS     = 4,
  parameter int WIDTH     = 34,
  parameter int AFULL_THR = 3,
  localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int OCUP_W   = $clog2(SLOTS) + 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     write_i,
  input  logic [VC_W-1:0]          write_vc_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     read_i,
  input  logic [VC_W-1:0]          read_vc_i,
  input  logic [NUM_VC-1:0]        flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [NUM_VC-1:0]        empty_o,
  output logic [NUM_VC-1:0]        full_o,
  output logic [NUM_VC-1:0]        afull_o,
  output logic [NUM_VC*OCUP_W-1:0] ocup_o,
  output logic                     error_o
);

  localparam int IDX_W = $clog2(SLOTS);
  typedef logic [OCUP_W-1:0] ptr_t;

  // Pointers differ only in the wrap bit when the queue is full.
  localparam ptr_t FULL_XOR = ptr_t'({1'b1, {IDX_W{1'b0}}});
  localparam logic [VC_W:0] NUM_VC_L = (VC_W+1)'(NUM_VC);
  localparam ptr_t AFULL_L = ptr_t'(AFULL_THR);

  ptr_t wptr_q [NUM_VC];
  ptr_t wptr_d [NUM_VC];
  ptr_t rptr_q [NUM_VC];
  ptr_t rptr_d [NUM_VC];
  ptr_t ocup_s [NUM_VC];

  // Flit storage is deliberately not reset; the pointers define validity.
  logic [WIDTH-1:0] mem_q [NUM_VC][SLOTS];

  logic [NUM_VC-1:0] empty_s;
  logic [NUM_VC-1:0] full_s;
  logic              wr_vld_s;
  logic              rd_vld_s;
  logic [VC_W-1:0]   wr_sel_s;
  logic [VC_W-1:0]   rd_sel_s;
  logic              same_s;
  logic              rd_ok_s;
  logic              wr_ok_s;
  logic              error_s;
  logic [WIDTH-1:0]  data_s;

  // Decode per-VC status from the registered pointers only.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      ocup_s[v]  = wptr_q[v] - rptr_q[v];
      empty_s[v] = (wptr_q[v] == rptr_q[v]);
      full_s[v]  = ((wptr_q[v] ^ rptr_q[v]) == FULL_XOR);
    end
  end

  // Validate VC indices; invalid ones are steered to VC0 and gated by *_vld_s.
  always_comb begin
    wr_vld_s = ({1'b0, write_vc_i} < NUM_VC_L);
    rd_vld_s = ({1'b0, read_vc_i} < NUM_VC_L);
    if (wr_vld_s) begin
      wr_sel_s = write_vc_i;
    end else begin
      wr_sel_s = '0;
    end
    if (rd_vld_s) begin
      rd_sel_s = read_vc_i;
    end else begin
      rd_sel_s = '0;
    end
    same_s = wr_vld_s & rd_vld_s & (write_vc_i == read_vc_i);
  end

  // Accept/reject decisions, error flag and read data for this cycle.
  always_comb begin
    rd_ok_s = read_i & rd_vld_s & ~empty_s[rd_sel_s] & ~flush_i[rd_sel_s];
    // A full VC still accepts a write when the same VC pops this cycle.
    wr_ok_s = write_i & wr_vld_s & ~flush_i[wr_sel_s] &
              (~full_s[wr_sel_s] | (rd_ok_s & same_s));
    // Requests hitting a VC under flush are dropped without error.
    error_s = (write_i & (~wr_vld_s |
                          (~flush_i[wr_sel_s] & full_s[wr_sel_s] & ~(rd_ok_s & same_s)))) |
              (read_i  & (~rd_vld_s |
                          (~flush_i[rd_sel_s] & empty_s[rd_sel_s])));
    if (rd_vld_s & ~empty_s[rd_sel_s]) begin
      data_s = mem_q[rd_sel_s][rptr_q[rd_sel_s][IDX_W-1:0]];
    end else begin
      data_s = '0;
    end
  end

  // Next pointer values: flush wins over any accepted write or read.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wptr_d[v] = wptr_q[v];
      rptr_d[v] = rptr_q[v];
      if (flush_i[v]) begin
        wptr_d[v] = '0;
        rptr_d[v] = '0;
      end else begin
        if (wr_ok_s && (wr_sel_s == VC_W'(v))) begin
          wptr_d[v] = wptr_q[v] + ptr_t'(1);
        end else begin
          wptr_d[v] = wptr_q[v];
        end
        if (rd_ok_s && (rd_sel_s == VC_W'(v))) begin
          rptr_d[v] = rptr_q[v] + ptr_t'(1);
        end else begin
          rptr_d[v] = rptr_q[v];
        end
      end
    end
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr_q[v] <= wptr_d[v];
        rptr_q[v] <= rptr_d[v];
      end
    end
  end

  // Flit storage write on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_sel_s][wptr_q[wr_sel_s][IDX_W-1:0]] <= data_i;
    end
  end

  // Pack per-VC status onto the output ports, VC0 in the LSBs.
  always_comb begin
    ocup_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      ocup_o[v*OCUP_W +: OCUP_W] = ocup_s[v];
      afull_o[v] = (ocup_s[v] >= AFULL_L);
    end
  end

  assign empty_o = empty_s;
  assign full_o  = full_s;
  assign data_o  = data_s;
  assign error_o = error_s;

endmodule

// File: tb/tb_vc_fifo.sv
// Bench for vc_fifo: directed steps from the test plan plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_vc_fifo;

  localparam int NUM_VC = 3;
  localparam int SLOTS  = 4;
  localparam int WIDTH  = 34;
  localparam int AFULL  = 3;
  localparam int VC_W   = 2;
  localparam int OCUP_W = 3;

  logic                     clk;
  logic                     arst;
  logic                     write_i;
  logic [VC_W-1:0]          write_vc_i;
  logic [WIDTH-1:0]         data_i;
  logic                     read_i;
  logic [VC_W-1:0]          read_vc_i;
  logic [NUM_VC-1:0]        flush_i;
  logic [WIDTH-1:0]         data_o;
  logic [NUM_VC-1:0]        empty_o;
  logic [NUM_VC-1:0]        full_o;
  logic [NUM_VC-1:0]        afull_o;
  logic [NUM_VC*OCUP_W-1:0] ocup_o;
  logic                     error_o;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue of flits per VC.
  logic [WIDTH-1:0] q [NUM_VC][$];

  // Current stimulus.
  logic             in_w;
  int               in_wvc;
  logic [WIDTH-1:0] in_d;
  logic             in_r;
  int               in_rvc;
  logic [NUM_VC-1:0] in_fl;

  vc_fifo #(.NUM_VC(NUM_VC), .SLOTS(SLOTS), .WIDTH(WIDTH), .AFULL_THR(AFULL)) dut (
    .clk(clk), .arst(arst), .write_i(write_i), .write_vc_i(write_vc_i),
    .data_i(data_i), .read_i(read_i), .read_vc_i(read_vc_i), .flush_i(flush_i),
    .data_o(data_o), .empty_o(empty_o), .full_o(full_o), .afull_o(afull_o),
    .ocup_o(ocup_o), .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decide acceptance and error from the queue contents and the request rules.
  function automatic void predict(output bit rd_ok, output bit wr_ok, output bit err);
    bit same;
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    err   = 1'b0;
    if (in_r) begin
      if (in_rvc >= NUM_VC) err = 1'b1;
      else if (!in_fl[in_rvc]) begin
        if (q[in_rvc].size() == 0) err = 1'b1;
        else rd_ok = 1'b1;
      end
    end
    if (in_w) begin
      if (in_wvc >= NUM_VC) err = 1'b1;
      else if (!in_fl[in_wvc]) begin
        same = rd_ok && (in_rvc == in_wvc);
        if (q[in_wvc].size() < SLOTS || same) wr_ok = 1'b1;
        else err = 1'b1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    bit rd_ok, wr_ok, err;
    logic [WIDTH-1:0] exp_d;
    logic [NUM_VC-1:0] e_empty, e_full, e_afull;
    logic [NUM_VC*OCUP_W-1:0] e_ocup;
    predict(rd_ok, wr_ok, err);
    exp_d = '0;
    if (in_rvc < NUM_VC && q[in_rvc].size() > 0) exp_d = q[in_rvc][0];
    e_ocup = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      e_empty[v] = (q[v].size() == 0);
      e_full[v]  = (q[v].size() == SLOTS);
      e_afull[v] = (q[v].size() >= AFULL);
      e_ocup[v*OCUP_W +: OCUP_W] = OCUP_W'(q[v].size());
    end
    chk({tag, ".data"},  64'(data_o),  64'(exp_d));
    chk({tag, ".error"}, 64'(error_o), 64'(err));
    chk({tag, ".empty"}, 64'(empty_o), 64'(e_empty));
    chk({tag, ".full"},  64'(full_o),  64'(e_full));
    chk({tag, ".afull"}, 64'(afull_o), 64'(e_afull));
    chk({tag, ".ocup"},  64'(ocup_o),  64'(e_ocup));
  endtask

  task automatic drive();
    write_i    = in_w;
    write_vc_i = in_wvc[VC_W-1:0];
    data_i     = in_d;
    read_i     = in_r;
    read_vc_i  = in_rvc[VC_W-1:0];
    flush_i    = in_fl;
  endtask

  // One clock: apply request, check outputs, advance model, cross the edge.
  task automatic step(input string tag, input logic w, input int wvc, input logic [WIDTH-1:0] d,
                      input logic r, input int rvc, input logic [NUM_VC-1:0] fl);
    bit rd_ok, wr_ok, err;
    in_w = w; in_wvc = wvc; in_d = d; in_r = r; in_rvc = rvc; in_fl = fl;
    drive();
    #1;
    check_all(tag);
    predict(rd_ok, wr_ok, err);
    for (int v = 0; v < NUM_VC; v++) begin
      if (fl[v]) q[v].delete();
    end
    if (rd_ok) void'(q[rvc].pop_front());
    if (wr_ok) q[wvc].push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_w = 1'b0; in_wvc = 0; in_d = '0; in_r = 1'b0; in_rvc = 0; in_fl = '0;
    drive();
  endtask

  initial begin
    logic [63:0] rnd;
    int fl_pick;
    arst = 1'b1;
    idle_inputs();
    #2;
    check_all("reset");
    #5 arst = 1'b0;
    @(posedge clk);
    #1;

    // Fill VC1, then overflow attempt.
    step("w1a", 1'b1, 1, 34'hA, 1'b0, 1, 3'b000);
    step("w1b", 1'b1, 1, 34'hB, 1'b0, 1, 3'b000);
    step("w1c", 1'b1, 1, 34'hC, 1'b0, 1, 3'b000);
    step("w1d", 1'b1, 1, 34'hD, 1'b0, 1, 3'b000);
    step("w1ovf", 1'b1, 1, 34'h3F, 1'b0, 1, 3'b000);
    // Pass-through on full VC1, then drain.
    step("pass", 1'b1, 1, 34'hE, 1'b1, 1, 3'b000);
    for (int i = 0; i < 4; i++) step("drain1", 1'b0, 0, 34'h0, 1'b1, 1, 3'b000);
    step("drain1e", 1'b0, 0, 34'h0, 1'b0, 1, 3'b000);
    // Empty VC0 read, then same-cycle write+read on empty VC0.
    step("rd0e", 1'b0, 0, 34'h0, 1'b1, 0, 3'b000);
    step("wr0e", 1'b1, 0, 34'h11, 1'b1, 0, 3'b000);
    // Interleave VC0/VC2 writes with VC2 reads.
    for (int i = 0; i < 6; i++) begin
      step("ilv_w0", 1'b1, 0, 34'(32'h100 + i), 1'b1, 2, 3'b000);
      step("ilv_w2", 1'b1, 2, 34'(32'h200 + i), 1'b1, 2, 3'b000);
    end
    // Wrap-around on VC0 with push/pop pairs.
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, 0, 34'(32'h300 + i), 1'b1, 0, 3'b000);
    // VC2 to exactly 3 entries, then flush with a concurrent write.
    step("fl2a", 1'b0, 0, 34'h0, 1'b0, 2, 3'b100);
    for (int i = 0; i < 3; i++) step("w2", 1'b1, 2, 34'(32'h400 + i), 1'b0, 2, 3'b000);
    step("fl2w", 1'b1, 2, 34'h4FF, 1'b0, 2, 3'b100);
    step("fl2post", 1'b0, 0, 34'h0, 1'b1, 2, 3'b000);
    // Invalid VC index.
    step("badw", 1'b1, 3, 34'h55, 1'b0, 0, 3'b000);
    step("badr", 1'b0, 0, 34'h0, 1'b1, 3, 3'b000);

    // Random traffic including invalid indices and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom};
      fl_pick = $urandom_range(0, 15);
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), rnd[WIDTH-1:0],
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           (fl_pick == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
    end

    // Make every VC non-empty, then reset mid-operation.
    for (int v = 0; v < NUM_VC; v++) step("prerst", 1'b1, v, 34'(32'h700 + v), 1'b0, 0, 3'b000);
    idle_inputs();
    arst = 1'b1;
    #1;
    for (int v = 0; v < NUM_VC; v++) q[v].delete();
    check_all("midrst");
    #2 arst = 1'b0;
    @(posedge clk);
    #1;
    step("postrst_w", 1'b1, 2, 34'h123, 1'b0, 2, 3'b000);
    step("postrst_r", 1'b0, 0, 34'h0, 1'b1, 2, 3'b000);
    step("postrst_e", 1'b0, 0, 34'h0, 1'b0, 2, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_fifo.md
# vc_fifo

Multi-channel successor to the single-queue `fifo` block, intended for router input ports. It holds NUM_VC independent circular FIFOs of SLOTS entries, one per virtual channel, each WIDTH bits wide. One write port and one read port are each steered by a VC index. Over the single-queue block it adds per-VC occupancy and almost-full flags, synchronous per-VC flush, full-with-read pass-through writes, and out-of-range index detection.

## Interface
- NUM_VC, 3, number of virtual channels (>=1)
- SLOTS, 4, entries per VC; power of 2, >=2
- WIDTH, 34, flit width in bits
- AFULL_THR, 3, almost-full threshold; range 1..SLOTS
- VC_W (derived), NUM_VC>1 ? $clog2(NUM_VC) : 1
- OCUP_W (derived), $clog2(SLOTS)+1
- clk  in  1  clock; reset arst, asynchronous, active-high; clock clk
- arst  in  1  asynchronous active-high reset
- write_i  in  1  write request
- write_vc_i  in  VC_W  target VC of write
- data_i  in  WIDTH  write data
- read_i  in  1  read (pop) request
- read_vc_i  in  VC_W  VC selected for data_o and pop
- flush_i  in  NUM_VC  per-VC synchronous flush
- data_o  out  WIDTH  head of read_vc_i queue; 0 if that queue is empty or the index is invalid
- empty_o  out  NUM_VC  per-VC empty
- full_o  out  NUM_VC  per-VC full
- afull_o  out  NUM_VC  per-VC occupancy >= AFULL_THR
- ocup_o  out  NUM_VC*OCUP_W  per-VC occupancy, VC0 in the LSBs
- error_o  out  1  illegal request this cycle

## Operation
- Per VC: write_ptr and read_ptr, each OCUP_W bits, with wrap bit as MSB. Index = low $clog2(SLOTS) bits.
- Empty when the pointers are equal. Full when the indices are equal and the wrap bits differ. ocup = write_ptr - read_ptr, modulo 2^OCUP_W, always 0..SLOTS.
- VC index is valid when < NUM_VC. An invalid index makes the request a no-op and raises error_o.
- Read accepted (rd_ok): read_i, valid read_vc_i, VC not empty, no flush on that VC. Effect: read_ptr+1.
- Write accepted (wr_ok): write_i, valid write_vc_i, no flush on that VC, and either (VC not full) or (rd_ok on the same VC this cycle). Effect: store data_i at write index, write_ptr+1.
- Write and read to the same empty VC in one cycle: read is rejected (no fall-through), write is accepted, error_o=1.
- Write and read to different VCs are independent and both may be accepted.
- flush_i[v]: next cycle read_ptr=write_ptr=0 for VC v. Flush has priority over any write or read to v. Stored data is not cleared. Flushing VC v does not affect other VCs.
- error_o = (write_i & (invalid write VC | (full & !same-VC rd_ok))) | (read_i & (invalid read VC | empty)). Requests to a VC being flushed are dropped silently, with no error.
- Storage is not reset. data_o is masked to 0 whenever the selected queue is empty.

## Timing
- Reset: all pointers 0, empty_o all 1, full_o 0, afull_o 0, ocup_o 0, data_o 0, error_o 0.
- Asserting arst mid-operation immediately discards all contents and forces the reset values above.
- Flags and ocup_o are decoded from registered pointers only. They change the cycle after an accepted op or flush.
- data_o and error_o are combinational from the current inputs and state.
- A written flit is visible on data_o at the earliest one cycle after the write: write-to-read latency is 1 cycle.
- Throughput: 1 write and 1 read per cycle, including to a full VC via pass-through.
- Pointer wrap: after 2*SLOTS accepted writes the pointer returns to 0, with no flag glitch.

## Test plan
- Reset, then write VC1 = 0xA, 0xB, 0xC, 0xD (SLOTS=4) -> ocup_o[VC1]=4, full_o=3'b010, afull_o[1]=1 once ocup reaches 3; a 5th write gives error_o=1 and the contents are unchanged.
- VC1 full, same-cycle read VC1 and write 0xE -> data_o=0xA, no error. Next cycle ocup stays 4 and the subsequent pops return 0xB, 0xC, 0xD, 0xE.
- Read empty VC0 -> error_o=1, data_o=0, pointers unchanged. Write and read VC0 in one cycle -> error_o=1, ocup=1 next cycle.
- Interleave writes to VC0/VC2 with reads from VC2 -> per-VC order is preserved and the VCs do not interfere. Run 20 push/pop pairs to confirm wrap-around.
- With VC2 holding 3 entries, pulse flush_i=3'b100 together with a write to VC2 -> next cycle empty_o[2]=1, ocup=0, write dropped, VC0/VC1 unchanged.
- write_vc_i=3 with NUM_VC=3 -> error_o=1, no state change. Assert arst with all VCs non-empty -> all outputs at reset values in the same cycle.
